// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the Alu issue arbiter
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int j;

    // Walk offsets from farthest to nearest so the lane closest to ptr wins last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (valid[j]) begin
                idx   = IDX_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin sharing of one registered Alu among NUM_REQ lanes
module alu_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = alu_arb_pkg::DATA_W,
    parameter int OP_W    = alu_arb_pkg::OP_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        io_req_valid,
    output logic [NUM_REQ-1:0]        io_req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   io_req_op,
    input  logic [NUM_REQ-1:0]        io_req_compare,
    input  logic [NUM_REQ*DATA_W-1:0] io_req_rs,
    input  logic [NUM_REQ*DATA_W-1:0] io_req_rt,
    output logic                      io_alu_execute,
    output logic [OP_W-1:0]           io_alu_operation,
    output logic                      io_alu_compare,
    output logic [DATA_W-1:0]         io_alu_rs,
    output logic [DATA_W-1:0]         io_alu_rt,
    input  logic [DATA_W-1:0]         io_alu_output,
    output logic [NUM_REQ-1:0]        io_resp_valid,
    input  logic [NUM_REQ-1:0]        io_resp_ready,
    output logic [DATA_W-1:0]         io_resp_data,
    output logic                      io_busy
);

    import alu_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, grant_q, win_idx, ptr_next;
    logic               win_found;
    logic               accept, resp_fire;
    logic [OP_W-1:0]    op_q;
    logic               cmp_q;
    logic [DATA_W-1:0]  rs_q, rt_q, result_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid (io_req_valid),
        .ptr   (ptr_q),
        .idx   (win_idx),
        .found (win_found)
    );

    assign accept    = (state_q == IDLE) && win_found;
    assign resp_fire = (state_q == RESP) && io_resp_ready[grant_q];
    assign ptr_next  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        state_d        = state_q;
        io_req_ready   = '0;
        io_resp_valid  = '0;
        io_alu_execute = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    // Ready is gated by reset so nothing is granted while reset is held.
                    io_req_ready[win_idx] = ~reset;
                    state_d               = ISSUE;
                end
            end
            ISSUE: begin
                io_alu_execute = 1'b1;
                state_d        = CAPTURE;
            end
            CAPTURE: begin
                state_d = RESP;
            end
            RESP: begin
                io_resp_valid[grant_q] = 1'b1;
                if (io_resp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            op_q     <= '0;
            cmp_q    <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= win_idx;
                op_q    <= io_req_op[win_idx*OP_W +: OP_W];
                cmp_q   <= io_req_compare[win_idx];
                rs_q    <= io_req_rs[win_idx*DATA_W +: DATA_W];
                rt_q    <= io_req_rt[win_idx*DATA_W +: DATA_W];
            end
            if (state_q == CAPTURE) begin
                result_q <= io_alu_output;
            end
            if (resp_fire) begin
                ptr_q <= ptr_next;
            end
        end
    end

    assign io_alu_operation = op_q;
    assign io_alu_compare   = cmp_q;
    assign io_alu_rs        = rs_q;
    assign io_alu_rt        = rt_q;
    assign io_resp_data     = result_q;
    assign io_busy          = (state_q != IDLE);

endmodule
